// File: rtl/isram_axi_rd_slave_pkg.sv
// Shared types and constants for the instruction SRAM read slave.
// Response codes, reset PC, FSM states and the LFSR step function.
package isram_axi_rd_slave_pkg;

  localparam logic [2:0] RESP_OKAY   = 3'b000;
  localparam logic [2:0] RESP_SLVERR = 3'b010;
  localparam logic [2:0] RESP_DECERR = 3'b011;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_e;

  // Galois step for x^8+x^6+x^5+x^4+1; a non-zero state never maps to 0
  function automatic logic [7:0] lfsr_next(input logic [7:0] q);
    lfsr_next = q[0] ? ((q >> 1) ^ 8'hB8) : (q >> 1);
  endfunction

endpackage

// File: rtl/isram_axi_rd_slave_lfsr8.sv
// Free-running 8-bit Galois LFSR used to randomise slave wait states.
// Shared by any random-stall memory model.
module lfsr8
  import isram_axi_rd_slave_pkg::*;
#(
  parameter logic [7:0] SEED = 8'h01
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [7:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= SEED;
    else        q <= lfsr_next(q);
  end

endmodule

// File: rtl/isram_axi_rd_slave.sv
// AR/R read responder for the instruction ROM seen by the fetch unit.
// One outstanding read; optional pseudo-random wait states.
module isram_axi_rd_slave
  import isram_axi_rd_slave_pkg::*;
#(
  parameter int          DATA_LEN   = 32,
  parameter logic [31:0] BASE_ADDR  = RST_PC,
  parameter int          DEPTH      = 4096,
  parameter logic [7:0]  DELAY_MASK = 8'h00,
  parameter logic [7:0]  LFSR_SEED  = 8'h01
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                arvalid,
  output logic                arready,
  input  logic [DATA_LEN-1:0] araddr,
  output logic                rvalid,
  input  logic                rready,
  output logic [DATA_LEN-1:0] rdata,
  output logic [2:0]          rresp
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [DATA_LEN-1:0] SPAN = DATA_LEN'(4 * DEPTH);
  localparam logic [DATA_LEN-1:0] BASE = DATA_LEN'(BASE_ADDR);

  logic [DATA_LEN-1:0] mem [0:DEPTH-1];

  state_e              state_q, state_d;
  logic [7:0]          lfsr, cnt_q, cnt_d;
  logic [DATA_LEN-1:0] addr_q, addr_d, addr_s, off;
  logic [AW-1:0]       idx;
  logic [2:0]          resp_s;
  logic                arready_d, rvalid_d;
  logic                load, clr;

  lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .q     (lfsr)
  );

  // zero-wait reads fetch on the handshake edge, before addr_q holds it
  assign addr_s = (state_q == IDLE) ? araddr : addr_q;
  assign off    = addr_s - BASE;
  assign idx    = off[AW+1:2];

  always_comb begin
    resp_s = RESP_OKAY;
    if (addr_s < BASE || off >= SPAN) resp_s = RESP_DECERR;
    else if (addr_s[1:0] != 2'b00)    resp_s = RESP_SLVERR;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    arready_d = arready;
    rvalid_d  = rvalid;
    load      = 1'b0;
    clr       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (arvalid && arready) begin
          addr_d    = araddr;
          cnt_d     = lfsr & DELAY_MASK;
          arready_d = 1'b0;
          if (cnt_d != 8'd0) begin
            state_d = WAIT;
          end else begin
            state_d  = RESP;
            rvalid_d = 1'b1;
            load     = 1'b1;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q <= 8'd1) begin
          state_d  = RESP;
          rvalid_d = 1'b1;
          load     = 1'b1;
        end
      end
      RESP: begin
        if (rready) begin
          state_d   = IDLE;
          rvalid_d  = 1'b0;
          arready_d = 1'b1;
        end
      end
      default: begin
        state_d   = IDLE;
        cnt_d     = 8'd0;
        arready_d = 1'b1;
        rvalid_d  = 1'b0;
        clr       = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      addr_q  <= '0;
      arready <= 1'b1;
      rvalid  <= 1'b0;
      rdata   <= '0;
      rresp   <= RESP_OKAY;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      arready <= arready_d;
      rvalid  <= rvalid_d;
      if (clr) begin
        rdata <= '0;
        rresp <= RESP_OKAY;
      end else if (load) begin
        rresp <= resp_s;
        rdata <= (resp_s == RESP_OKAY) ? mem[idx] : '0;
      end
    end
  end

endmodule

// File: tb/tb_isram_axi_rd_slave.sv
// Directed bench for isram_axi_rd_slave: fixed and random latency instances.
// Both see the same inputs; sel picks which one the checks observe.
module tb_isram_axi_rd_slave;

  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam int          DEP  = 256;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        arvalid = 1'b0;
  logic        rready = 1'b0;
  logic [31:0] araddr = '0;
  logic        sel = 1'b0;

  logic        f_arready, f_rvalid, r_arready, r_rvalid;
  logic [31:0] f_rdata, r_rdata;
  logic [2:0]  f_rresp, r_rresp;

  logic        s_arready, s_rvalid;
  logic [31:0] s_rdata;
  logic [2:0]  s_rresp;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  isram_axi_rd_slave #(
    .BASE_ADDR (BASE), .DEPTH (DEP), .DELAY_MASK (8'h00)
  ) u_fix (
    .clk (clk), .rst_n (rst_n),
    .arvalid (arvalid), .arready (f_arready), .araddr (araddr),
    .rvalid (f_rvalid), .rready (rready),
    .rdata (f_rdata), .rresp (f_rresp)
  );

  isram_axi_rd_slave #(
    .BASE_ADDR (BASE), .DEPTH (DEP), .DELAY_MASK (8'h07)
  ) u_rnd (
    .clk (clk), .rst_n (rst_n),
    .arvalid (arvalid), .arready (r_arready), .araddr (araddr),
    .rvalid (r_rvalid), .rready (rready),
    .rdata (r_rdata), .rresp (r_rresp)
  );

  assign s_arready = sel ? r_arready : f_arready;
  assign s_rvalid  = sel ? r_rvalid  : f_rvalid;
  assign s_rdata   = sel ? r_rdata   : f_rdata;
  assign s_rresp   = sel ? r_rresp   : f_rresp;

  // addi x1, x1, i
  function automatic logic [31:0] img(input int i);
    logic [11:0] imm;
    imm = 12'(i);
    img = {imm, 5'd1, 3'b000, 5'd1, 7'h13};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [31:0] a, output int lat);
    int k;
    @(negedge clk);
    arvalid = 1'b1;
    araddr  = a;
    k = 0;
    while (!s_arready && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("ar_ready", s_arready, 1);
    @(negedge clk);
    arvalid = 1'b0;
    lat = 1;
    while (!s_rvalid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    chk("r_valid", s_rvalid, 1);
    chk("ar_low", s_arready, 0);
  endtask

  task automatic finish_r();
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    chk("r_done", s_rvalid, 0);
    chk("ar_back", s_arready, 1);
  endtask

  task automatic rd(input string tag, input logic [31:0] a,
                    input logic [31:0] ed, input logic [2:0] er,
                    output int lat);
    issue(a, lat);
    chk({tag, "_data"}, s_rdata, ed);
    chk({tag, "_resp"}, s_rresp, er);
    finish_r();
  endtask

  initial begin
    int          lat;
    int          found;
    int          stable;
    int          n;
    int          cyc;
    logic [7:0]  seen;
    logic [31:0] snap_d;
    logic [2:0]  snap_r;
    logic [31:0] pc;

    for (int i = 0; i < DEP; i++) begin
      u_fix.mem[i] = img(i);
      u_rnd.mem[i] = img(i);
    end
    repeat (3) @(negedge clk);
    chk("rst_arready", s_arready, 1);
    chk("rst_rvalid", s_rvalid, 0);
    chk("rst_rdata", s_rdata, 0);
    chk("rst_rresp", s_rresp, 0);
    rst_n = 1'b1;

    // minimum latency read of word 0
    issue(BASE, lat);
    chk("t1_lat", lat, 1);
    chk("t1_data", s_rdata, img(0));
    chk("t1_resp", s_rresp, 3'b000);
    finish_r();

    rd("slverr", BASE + 32'h2, 32'h0, 3'b010, lat);
    rd("decerr_lo", 32'h7FFF_FFFC, 32'h0, 3'b011, lat);
    rd("decerr_hi", BASE + 32'h400, 32'h0, 3'b011, lat);
    rd("decerr_both", 32'h7FFF_FFFE, 32'h0, 3'b011, lat);
    rd("last_word", BASE + 32'h3FC, img(255), 3'b000, lat);
    chk("err_lat", lat, 1);

    // long rready stall with stray AR pulses
    issue(BASE + 32'h10, lat);
    snap_d = s_rdata;
    snap_r = s_rresp;
    chk("hold_data0", snap_d, img(4));
    stable = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      arvalid = (i % 3 == 0);
      araddr  = BASE + 32'h40;
      if (!s_rvalid || s_arready || s_rdata !== snap_d || s_rresp !== snap_r)
        stable = 0;
    end
    arvalid = 1'b0;
    chk("hold_stable", stable, 1);
    finish_r();
    rd("after_hold", BASE + 32'h14, img(5), 3'b000, lat);

    // switch to the random-latency instance from a clean state
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    sel = 1'b1;

    seen = '0;
    n = 0;
    for (int i = 0; i < 200; i++) begin
      issue(BASE + 32'(4 * i), lat);
      if (s_rdata !== img(i) || s_rresp !== 3'b000 || lat < 1 || lat > 8)
        n++;
      if (lat >= 1 && lat <= 8) seen[lat-1] = 1'b1;
      finish_r();
    end
    chk("seq_bad_reads", n, 0);
    chk("lat_variety", ($countones(seen) >= 4), 1);

    // reset while waiting
    found = 0;
    for (int t = 0; t < 40 && found == 0; t++) begin
      @(negedge clk);
      arvalid = 1'b1;
      araddr  = BASE + 32'h20;
      @(negedge clk);
      arvalid = 1'b0;
      if (!s_rvalid) begin
        found = 1;
        rst_n = 1'b0;
        #1;
        chk("rst_wait_rvalid", s_rvalid, 0);
        chk("rst_wait_arready", s_arready, 1);
        @(negedge clk);
        rst_n = 1'b1;
      end else begin
        finish_r();
      end
    end
    chk("wait_reached", found, 1);
    rd("post_rst_wait", BASE + 32'h24, img(9), 3'b000, lat);

    // reset while responding
    issue(BASE + 32'h28, lat);
    rst_n = 1'b0;
    #1;
    chk("rst_resp_rvalid", s_rvalid, 0);
    chk("rst_resp_arready", s_arready, 1);
    chk("rst_resp_rdata", s_rdata, 0);
    @(negedge clk);
    rst_n = 1'b1;
    rd("post_rst_resp", BASE + 32'h2C, img(11), 3'b000, lat);

    // fetch-unit style back-to-back loop
    pc = BASE;
    n = 0;
    cyc = 0;
    @(negedge clk);
    arvalid = 1'b1;
    araddr  = pc;
    rready  = 1'b1;
    while (n < 40 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      if (s_rvalid) begin
        chk("ifu_inst", s_rdata, img(n));
        n++;
        pc = pc + 32'd4;
        araddr = pc;
      end
    end
    arvalid = 1'b0;
    rready  = 1'b0;
    chk("ifu_count", n, 40);
    chk("ifu_pc_end", pc, BASE + 32'd160);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
